// File: rtl/lsu_memory.sv
// Memory-stage load/store unit with a word-organised synchronous data memory.
// Accesses that straddle a word boundary are split over two cycles (IDLE -> SECOND).
module lsu_memory #(
   parameter int unsigned DEPTH = 2048
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_insn_vld_memory,
   input  logic        i_mem_wren_memory,
   input  logic [1:0]  i_wb_sel_memory,
   input  logic [2:0]  i_sl_sel_memory,
   input  logic [31:0] i_alu_data_memory,
   input  logic [31:0] i_pre_opb_memory,
   output logic [31:0] o_ld_data,
   output logic        o_ld_vld,
   output logic        o_stall,
   output logic        o_misaligned
);
   localparam int unsigned IW = $clog2(DEPTH);

   typedef enum logic {IDLE, SECOND} state_e;
   state_e state_q, state_d;

   logic [31:0]   mem_q [DEPTH];
   logic [31:0]   rd_word_q;
   logic [31:0]   lo_q;

   logic          st_req, ld_req, req, mis;
   logic [IW-1:0] w_idx;
   logic [1:0]    off;
   logic [3:0]    base_be;
   logic [7:0]    be8;
   logic [63:0]   wd64;

   logic          accept, ld_vld_d;
   logic          mem_we, mem_re;
   logic [IW-1:0] mem_idx;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;

   logic          ld_vld_q, mis_q;
   logic [IW-1:0] nxt_idx_q;
   logic [3:0]    hi_be_q;
   logic [31:0]   hi_data_q;
   logic          split_st_q;
   logic [2:0]    sel_q;
   logic [1:0]    off_q;
   logic          split_q;

   logic          unused_addr;
   assign unused_addr = ^i_alu_data_memory[31:IW+2];

   always_comb begin
      st_req = i_insn_vld_memory & i_mem_wren_memory;
      ld_req = i_insn_vld_memory & ~i_mem_wren_memory & (i_wb_sel_memory == 2'b10);
      req    = st_req | ld_req;
      off    = i_alu_data_memory[1:0];
      w_idx  = i_alu_data_memory[IW+1:2];
      case (i_sl_sel_memory)
         3'b000, 3'b100: base_be = 4'b0001;
         3'b001, 3'b101: base_be = 4'b0011;
         default:        base_be = 4'b1111;
      endcase
      // Upper nibble of the shifted mask holds the bytes that spill into word w+1.
      be8  = {4'b0000, base_be} << off;
      wd64 = {32'b0, i_pre_opb_memory} << {off, 3'b000};
      mis  = |be8[7:4];
   end

   always_comb begin
      state_d   = state_q;
      o_stall   = 1'b0;
      accept    = 1'b0;
      ld_vld_d  = 1'b0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_idx   = w_idx;
      mem_be    = be8[3:0];
      mem_wdata = wd64[31:0];
      if (i_reset) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  accept = 1'b1;
                  mem_we = st_req;
                  mem_re = ld_req;
                  if (mis) begin
                     state_d = SECOND;
                     o_stall = 1'b1;
                  end else begin
                     ld_vld_d = ld_req;
                  end
               end
            end
            SECOND: begin
               mem_idx   = nxt_idx_q;
               mem_be    = hi_be_q;
               mem_wdata = hi_data_q;
               mem_we    = split_st_q;
               mem_re    = ~split_st_q;
               ld_vld_d  = ~split_st_q;
               state_d   = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= IDLE;
         ld_vld_q   <= 1'b0;
         mis_q      <= 1'b0;
         nxt_idx_q  <= '0;
         hi_be_q    <= '0;
         hi_data_q  <= '0;
         split_st_q <= 1'b0;
         sel_q      <= '0;
         off_q      <= '0;
         split_q    <= 1'b0;
         lo_q       <= '0;
      end else begin
         state_q  <= state_d;
         ld_vld_q <= ld_vld_d;
         if (accept) begin
            mis_q      <= mis;
            nxt_idx_q  <= w_idx + IW'(1);
            hi_be_q    <= be8[7:4];
            hi_data_q  <= wd64[63:32];
            split_st_q <= st_req;
         end
         // Formatting info tracks loads only so an intervening store cannot corrupt a pending result.
         if (accept && ld_req) begin
            sel_q   <= i_sl_sel_memory;
            off_q   <= off;
            split_q <= mis;
         end
         if (state_q == SECOND) begin
            lo_q <= rd_word_q;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (mem_be[b]) begin
               mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
      if (mem_re) begin
         rd_word_q <= mem_q[mem_idx];
      end
   end

   logic [63:0] src;
   logic [31:0] shw;
   logic [31:0] ld_ext;

   always_comb begin
      src = split_q ? {rd_word_q, lo_q} : {32'b0, rd_word_q};
      shw = 32'(src >> {off_q, 3'b000});
      case (sel_q)
         3'b000:  ld_ext = {{24{shw[7]}}, shw[7:0]};
         3'b100:  ld_ext = {24'b0, shw[7:0]};
         3'b001:  ld_ext = {{16{shw[15]}}, shw[15:0]};
         3'b101:  ld_ext = {16'b0, shw[15:0]};
         default: ld_ext = shw;
      endcase
      o_ld_data = ld_vld_q ? ld_ext : '0;
   end

   assign o_ld_vld     = ld_vld_q;
   assign o_misaligned = mis_q;

endmodule

// File: tb/tb_lsu_memory.sv
// Directed bench for lsu_memory: a byte-array memory model predicts load results,
// stall and misaligned flag every cycle; literal checks pin the model.
module tb_lsu_memory;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned NB    = DEPTH * 4;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_insn_vld_memory;
   logic        i_mem_wren_memory;
   logic [1:0]  i_wb_sel_memory;
   logic [2:0]  i_sl_sel_memory;
   logic [31:0] i_alu_data_memory;
   logic [31:0] i_pre_opb_memory;
   logic [31:0] o_ld_data;
   logic        o_ld_vld;
   logic        o_stall;
   logic        o_misaligned;

   always #5 clk = ~clk;

   lsu_memory #(.DEPTH(DEPTH)) dut (
      .i_clk             (clk),
      .i_reset           (i_reset),
      .i_insn_vld_memory (i_insn_vld_memory),
      .i_mem_wren_memory (i_mem_wren_memory),
      .i_wb_sel_memory   (i_wb_sel_memory),
      .i_sl_sel_memory   (i_sl_sel_memory),
      .i_alu_data_memory (i_alu_data_memory),
      .i_pre_opb_memory  (i_pre_opb_memory),
      .o_ld_data         (o_ld_data),
      .o_ld_vld          (o_ld_vld),
      .o_stall           (o_stall),
      .o_misaligned      (o_misaligned)
   );

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   bit          chk_en = 1'b0;
   bit          exp_stall = 1'b0;
   bit          exp_mis = 1'b0;
   bit          mis_next = 1'b0;
   bit          mis_upd = 1'b1;
   logic [31:0] last_ld = '0;
   logic [7:0]  mb [NB];

   typedef struct {
      int          due;
      logic [31:0] data;
   } ld_t;
   ld_t ldq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int unsigned nbytes(input logic [2:0] sel);
      case (sel)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] sel);
      int unsigned a = addr % NB;
      int unsigned n = nbytes(sel);
      logic [31:0] v = '0;
      for (int unsigned i = 0; i < n; i++) v = v | (32'(mb[(a + i) % NB]) << (8 * i));
      if (sel == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
      if (sel == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (mis_upd) begin
         exp_mis = mis_next;
         mis_upd = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("stall", {31'b0, o_stall}, {31'b0, exp_stall});
         check("misaligned", {31'b0, o_misaligned}, {31'b0, exp_mis});
         if (ldq.size() > 0 && ldq[0].due == cyc) begin
            check("ld_vld", {31'b0, o_ld_vld}, 32'd1);
            check("ld_data", o_ld_data, ldq[0].data);
            last_ld = o_ld_data;
            void'(ldq.pop_front());
         end else begin
            check("ld_vld_idle", {31'b0, o_ld_vld}, 32'd0);
         end
      end
   end

   task automatic issue(input logic vld, input logic wren, input logic [1:0] wb,
                        input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] data);
      bit st, ld, mis;
      int unsigned n, a;
      ld_t e;
      @(posedge clk); #1;
      i_insn_vld_memory = vld;
      i_mem_wren_memory = wren;
      i_wb_sel_memory   = wb;
      i_sl_sel_memory   = sel;
      i_alu_data_memory = addr;
      i_pre_opb_memory  = data;
      st  = vld && wren;
      ld  = vld && !wren && (wb == 2'b10);
      n   = nbytes(sel);
      a   = addr % NB;
      mis = (st || ld) && ((addr % 4) + n > 4);
      if (st) for (int unsigned i = 0; i < n; i++) mb[(a + i) % NB] = data[8*i +: 8];
      if (ld) begin
         e.due  = cyc + (mis ? 2 : 1);
         e.data = model_load(addr, sel);
         ldq.push_back(e);
      end
      if (st || ld) begin
         mis_next = mis;
         mis_upd  = 1'b1;
      end
      exp_stall = mis;
      if (mis) begin
         @(posedge clk); #1;
         exp_stall = 1'b0;
      end
   endtask

   task automatic sw(input logic [31:0] addr, input logic [31:0] d);
      issue(1'b1, 1'b1, 2'b00, 3'b010, addr, d);
   endtask
   task automatic shw(input logic [31:0] addr, input logic [31:0] d);
      issue(1'b1, 1'b1, 2'b00, 3'b001, addr, d);
   endtask
   task automatic ld(input logic [2:0] sel, input logic [31:0] addr);
      issue(1'b1, 1'b0, 2'b10, sel, addr, 32'h0);
   endtask
   task automatic idle();
      issue(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
   endtask
   task automatic lit(input string name, input logic [31:0] v);
      @(negedge clk); #1;
      check(name, last_ld, v);
   endtask

   initial begin
      i_reset = 1'b1;
      i_insn_vld_memory = 1'b0;
      i_mem_wren_memory = 1'b0;
      i_wb_sel_memory   = 2'b00;
      i_sl_sel_memory   = 3'b000;
      i_alu_data_memory = '0;
      i_pre_opb_memory  = '0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      check("rst_ld_vld", {31'b0, o_ld_vld}, 32'd0);
      check("rst_ld_data", o_ld_data, 32'h0);
      check("rst_mis", {31'b0, o_misaligned}, 32'd0);
      check("rst_stall", {31'b0, o_stall}, 32'd0);
      @(posedge clk); #1;
      i_reset = 1'b0;

      sw(32'h10, 32'hDEADBEEF);
      ld(3'b010, 32'h10); idle(); lit("lw_10", 32'hDEADBEEF);
      ld(3'b000, 32'h13); idle(); lit("lb_13", 32'hFFFFFFDE);
      ld(3'b100, 32'h13); idle(); lit("lbu_13", 32'h000000DE);
      ld(3'b001, 32'h12); idle(); lit("lh_12", 32'hFFFFDEAD);
      ld(3'b101, 32'h10); idle(); lit("lhu_10", 32'h0000BEEF);
      ld(3'b010, 32'h10); ld(3'b000, 32'h11); ld(3'b101, 32'h12); ld(3'b011, 32'h10);
      idle();

      issue(1'b0, 1'b1, 2'b10, 3'b010, 32'h10, 32'h0);
      issue(1'b1, 1'b0, 2'b01, 3'b010, 32'h10, 32'h0);

      sw(32'h20, 32'hA0A1A2A3);
      sw(32'h24, 32'h55565758);
      sw(32'h21, 32'h11223344);
      check("mis_lit_st", {31'b0, o_misaligned}, 32'd1);
      ld(3'b010, 32'h20); idle(); lit("lw_20_after_mis", 32'h223344A3);
      ld(3'b010, 32'h24); idle(); lit("lw_24_after_mis", 32'h55565711);

      sw(32'h20, 32'hAABBCCDD);
      sw(32'h24, 32'h11223344);
      ld(3'b010, 32'h23); idle(); lit("lw_23_mis", 32'h223344AA);
      ld(3'b001, 32'h23); idle(); lit("lh_23_mis", 32'h000044AA);
      ld(3'b001, 32'h21); idle(); lit("lh_21", 32'hFFFFBBCC);
      ld(3'b010, 32'h21); ld(3'b110, 32'h26); ld(3'b010, 32'h24);
      idle();

      sw(32'h3C, 32'h01020304);
      sw(32'h00, 32'h05060708);
      shw(32'h3F, 32'h0000BEEF);
      ld(3'b010, 32'h3C); idle(); lit("wrap_w15", 32'hEF020304);
      ld(3'b010, 32'h00); idle(); lit("wrap_w0", 32'h050607BE);

      @(posedge clk); #1;
      i_insn_vld_memory = 1'b1;
      i_mem_wren_memory = 1'b0;
      i_wb_sel_memory   = 2'b10;
      i_sl_sel_memory   = 3'b010;
      i_alu_data_memory = 32'h23;
      mis_next  = 1'b1;
      mis_upd   = 1'b1;
      exp_stall = 1'b1;
      @(posedge clk); #1;
      i_reset   = 1'b1;
      exp_stall = 1'b0;
      mis_next  = 1'b0;
      mis_upd   = 1'b1;
      @(posedge clk); #1;
      i_reset = 1'b0;
      i_insn_vld_memory = 1'b0;
      check("rst2_ld_vld", {31'b0, o_ld_vld}, 32'd0);
      check("rst2_stall", {31'b0, o_stall}, 32'd0);
      ld(3'b010, 32'h20); idle(); lit("lw_after_rst", 32'hAABBCCDD);

      idle(); idle();
      @(negedge clk); #1;
      check("queue_drained", ldq.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lsu_memory.md
Name: lsu_memory

Overview:
- Memory-stage load/store unit.
- Consumes the EX/MEM pipeline register outputs (address = ALU result, store data = forwarded rs2, control fields) and owns the single-port, word-organised synchronous data memory.
- Produces sign/zero-extended load data one cycle later, aligned with the MEM/WB register.
- Splits misaligned halfword/word accesses into two word accesses, stalling upstream for one cycle.

Parameters:
DEPTH, 2048, data memory size in 32-bit words (power of two); word index = addr[$clog2(DEPTH)+1:2], wraps modulo DEPTH

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  synchronous, active-high reset
i_insn_vld_memory  in  1  instruction in MEM stage is valid
i_mem_wren_memory  in  1  store request
i_wb_sel_memory  in  2  writeback select; 2'b10 marks a load
i_sl_sel_memory  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_alu_data_memory  in  32  byte address
i_pre_opb_memory  in  32  store data (low bytes used)
o_ld_data  out  32  extended load data, valid with o_ld_vld
o_ld_vld  out  1  one-cycle pulse, load data ready
o_stall  out  1  hold PC/IF/ID/EX and EX/MEM registers this cycle
o_misaligned  out  1  registered flag, last accepted access was split

Behaviour:
- Reset: synchronous, active-high. Sets o_ld_data=0, o_ld_vld=0, o_misaligned=0, FSM=IDLE; o_stall=0 while i_reset high. Memory contents are not reset.
- Request definitions:
  - Store = insn_vld & mem_wren.
  - Load = insn_vld & ~mem_wren & wb_sel==2'b10.
  - Otherwise no access; o_ld_vld=0 next cycle.
- Unlisted sl_sel codes (011, 110, 111) are treated as W.
- Misaligned access: H with addr[1:0]==11, or W with addr[1:0]!=00. Byte accesses are never misaligned.
- FSM states: IDLE, SECOND.
- IDLE, aligned request: one memory access this cycle; o_stall=0; stay IDLE.
- IDLE, misaligned request:
  - Access word w=addr word index this cycle.
  - Latch the second-half info (w+1 mod DEPTH, remaining byte enables/data, sl_sel, offset).
  - o_stall=1, driven combinationally from inputs in this state.
  - Next state SECOND. Upstream holds its inputs unchanged.
- SECOND: access word w+1 using latched info only (inputs ignored); o_stall=0; next state IDLE.
- Stores:
  - Byte enables and data are shifted by addr[1:0]; bytes beyond word end go to w+1.
  - A write is committed at the edge ending its access cycle.
  - SB writes 1 byte, SH 2, SW 4; untouched bytes are preserved.
- Loads:
  - Read latency is 1 cycle.
  - Aligned: o_ld_vld=1 and o_ld_data valid in the cycle after the access.
  - Misaligned: low bytes from word w are captured in SECOND; o_ld_vld pulses the cycle after SECOND with bytes merged.
  - Total occupancy: 2 cycles.
- Extension: B/H sign-extended from bit 7/15; BU/HU zero-extended; W unchanged.
- o_misaligned: updated at every access start, i.e. every request in IDLE; holds its value otherwise.
- Ordering: a store followed by a load to the same word in the next cycle returns the stored data. The memory is write-first across cycles; there is never a same-cycle conflict because the memory is single-port and one access happens per cycle.
- Wrap-around: misaligned access at word DEPTH-1 continues at word 0.
- Reset in SECOND: second write/read aborted, no o_ld_vld pulse; first-half store already committed remains.
- Back-to-back aligned accesses sustain one per cycle with no stall.

Test Plan:
- Reset then SW 0xDEADBEEF @0x10; LW @0x10 next cycle -> o_ld_vld=1 one cycle after LW with o_ld_data=0xDEADBEEF, o_stall never high.
- After mem[0x10]=0xDEADBEEF: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
- SW 0x11223344 @0x21 (misaligned) -> o_stall=1 exactly one cycle, o_misaligned=1; then LW @0x20 -> 0x22334400|orig byte0, LW @0x24 -> upper bytes orig, byte0=0x11.
- Misaligned LW @0x23 over known words 0xAABBCCDD/0x11223344 -> o_stall 1 cycle, o_ld_vld pulses 2 cycles after request with 0x223344AA.
- SH 0xBEEF at last byte of word DEPTH-1 -> byte 0xEF in word DEPTH-1 byte3, 0xBE in word 0 byte0.
- Misaligned LW with i_reset asserted during SECOND -> no o_ld_vld, o_stall=0, FSM IDLE; next aligned LW completes normally.
